// File: rtl/t07_fpu_issue_ctrl.sv
// Issue/sequencing stage around t07_FPU: latch, wait out FDIV, hand off to WB.
// Optional WB->EXEC overlap: define T07_FPU_ISSUE_OVERLAP_EN.
module t07_fpu_issue_ctrl #(
  parameter int         DIV_TIMEOUT = 64,
  parameter logic [4:0] IDLE_OP     = 5'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_op,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [31:0] issue_c,
  input  logic [4:0]  issue_rd,
  input  logic        issue_int_dest,
  output logic [4:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [31:0] fpu_c,
  input  logic [31:0] fpu_result,
  input  logic        fpu_busy,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_int_dest,
  output logic [4:0]  fflags,
  input  logic        fflags_clr
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t      state;
  logic        live;
  logic [4:0]  op_q;
  logic [4:0]  rd_q;
  logic        intd_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] c_q;
  logic [CW-1:0] cnt;

  logic        acc;
  logic        done;
  logic [31:0] res;
  logic [4:0]  nflags;
  logic        is_div;
  logic        bz;
  logic        tmo;
  logic        ill;

`ifdef T07_FPU_ISSUE_OVERLAP_EN
  assign issue_ready = live &
    ((state == IDLE) | ((state == WB) & wb_ready));
`else
  assign issue_ready = live & (state == IDLE);
`endif

  assign acc = issue_valid & issue_ready;

  assign fpu_op = (state == EXEC) ? op_q : IDLE_OP;
  assign fpu_a  = (state == EXEC) ? a_q  : '0;
  assign fpu_b  = (state == EXEC) ? b_q  : '0;
  assign fpu_c  = (state == EXEC) ? c_q  : '0;

  assign ill    = op_q > 5'd23;
  assign is_div = op_q == 5'd7;
  assign bz     = b_q == '0;
  assign tmo    = cnt == CW'(DIV_TIMEOUT - 1);

  // flags are {NV,DZ,OF,UF,NX}
  always_comb begin
    done   = 1'b1;
    res    = fpu_result;
    nflags = '0;
    unique case (1'b1)
      ill: begin
        res    = '0;
        nflags = 5'b10000;
      end
      is_div & bz: begin
        res    = a_q[31] ? 32'h8000_0000 : 32'h7fff_ffff;
        nflags = 5'b01000;
      end
      is_div & ~bz & fpu_busy & tmo: begin
        res    = '0;
        nflags = 5'b10000;
      end
      is_div & ~bz & fpu_busy & ~tmo: begin
        done = 1'b0;
      end
      op_q == 5'd21: begin
        nflags[2] = a_q[31:16] != {16{a_q[15]}};
      end
      op_q == 5'd22: begin
        nflags[2] = |a_q[31:16];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      live        <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      intd_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      cnt         <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_int_dest <= 1'b0;
      fflags      <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        EXEC: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            wb_data     <= res;
            wb_rd       <= rd_q;
            wb_int_dest <= intd_q;
            wb_valid    <= 1'b1;
            state       <= WB;
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: ;
      endcase
      // a new accept overrides the WB->IDLE return
      if (acc) begin
        op_q   <= issue_op;
        a_q    <= issue_a;
        b_q    <= issue_b;
        c_q    <= issue_c;
        rd_q   <= issue_rd;
        intd_q <= issue_int_dest;
        cnt    <= '0;
        state  <= EXEC;
      end
      if (state == EXEC && done)
        fflags <= (fflags_clr ? 5'b0 : fflags) | nflags;
      else if (fflags_clr)
        fflags <= '0;
    end
  end

endmodule

// File: tb/tb_t07_fpu_issue_ctrl.sv
// Scoreboard bench for t07_fpu_issue_ctrl with a stub FPU.
// Directed vectors; monitor checks every writeback against the queue.
module tb_t07_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_op = '0;
  logic [31:0] issue_a = '0;
  logic [31:0] issue_b = '0;
  logic [31:0] issue_c = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_int_dest = 1'b0;
  logic [4:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_c;
  logic [31:0] fpu_result;
  logic        fpu_busy;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_int_dest;
  logic [4:0]  fflags;
  logic        fflags_clr = 1'b0;

`ifdef T07_FPU_ISSUE_OVERLAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  always #5 clk = ~clk;

  t07_fpu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_a(issue_a),
    .issue_b(issue_b), .issue_c(issue_c),
    .issue_rd(issue_rd), .issue_int_dest(issue_int_dest),
    .fpu_op(fpu_op), .fpu_a(fpu_a),
    .fpu_b(fpu_b), .fpu_c(fpu_c),
    .fpu_result(fpu_result), .fpu_busy(fpu_busy),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_int_dest(wb_int_dest),
    .fflags(fflags), .fflags_clr(fflags_clr)
  );

  // stub FPU: adds for non-divide ops, scripted busy for FDIV
  int          busy_cnt = 0;
  bit          busy_stuck = 1'b0;
  logic [31:0] div_res = '0;

  assign fpu_busy = (fpu_op == 5'd7) &&
                    (busy_stuck || busy_cnt > 0);
  assign fpu_result = (fpu_op == 5'd7) ? div_res
                                       : fpu_a + fpu_b;

  always @(posedge clk)
    if (fpu_op == 5'd7 && busy_cnt > 0)
      busy_cnt <= busy_cnt - 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int npass = 0;
  int ntot = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        intd;
    logic [4:0]  flags;
    int          due;
  } exp_t;

  exp_t q[$];
  bit   seen = 1'b0;

  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_wb", wb_valid, 1'b0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("wb_latency", cyc, q[0].due);
          chk("fflags_at_wb", fflags, q[0].flags);
        end
        chk("wb_data", wb_data, q[0].data);
        chk("wb_rd", wb_rd, q[0].rd);
        chk("wb_int_dest", wb_int_dest, q[0].intd);
        if (!wb_ready)
          chk("issue_ready_in_wb", issue_ready, 1'b0);
        else begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] rd,
                       input logic intd,
                       input logic [31:0] ed,
                       input logic [4:0] ef,
                       input int lat,
                       input bit push,
                       output int c0);
    exp_t e;
    int n = 0;
    c0 = cyc;
    @(negedge clk);
    while (!issue_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!issue_ready) begin
      chk("issue_wait", issue_ready, 1'b1);
      return;
    end
    issue_op = op;
    issue_a = a;
    issue_b = b;
    issue_c = 32'hc0de_0000 | 32'(rd);
    issue_rd = rd;
    issue_int_dest = intd;
    issue_valid = 1'b1;
    c0 = cyc;
    if (push) begin
      e.data = ed;
      e.rd = rd;
      e.intd = intd;
      e.flags = ef;
      e.due = c0 + lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1 issue_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || wb_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic clr_pulse();
    @(posedge clk);
    #1 fflags_clr = 1'b1;
    @(posedge clk);
    #1 fflags_clr = 1'b0;
    @(negedge clk);
    chk("fflags_cleared", fflags, 5'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int c0;
    int c1;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_issue_ready", issue_ready, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_fflags", fflags, 5'b0);
    chk("rst_fpu_op", fpu_op, 5'd8);
    chk("rst_fpu_a", fpu_a, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", issue_ready, 1'b1);

    // FADD, 2-cycle latency
    issue(5'd4, 32'd5, 32'd7, 5'd3, 1'b0,
          32'd12, 5'b0, 2, 1'b1, c0);
    drain();
    chk("idle_fpu_op", fpu_op, 5'd8);
    chk("idle_fpu_c", fpu_c, 32'h0);

    // FDIV by zero, both signs
    issue(5'd7, 32'd100, 32'd0, 5'd5, 1'b0,
          32'h7fff_ffff, 5'b01000, 2, 1'b1, c0);
    issue(5'd7, 32'hffff_ff9c, 32'd0, 5'd6, 1'b0,
          32'h8000_0000, 5'b01000, 2, 1'b1, c0);
    drain();
    clr_pulse();

    // FDIV stall: busy 10 EXEC cycles
    busy_cnt = 10;
    div_res = 32'd25;
    issue(5'd7, 32'd50, 32'd2, 5'd7, 1'b0,
          32'd25, 5'b0, 12, 1'b1, c0);
    @(negedge clk);
    chk("exec_fpu_op", fpu_op, 5'd7);
    chk("exec_fpu_b", fpu_b, 32'd2);
    chk("exec_fpu_c", fpu_c, 32'hc0de_0007);
    chk("exec_busy", fpu_busy, 1'b1);
    chk("exec_issue_ready", issue_ready, 1'b0);
    drain();

    // FDIV timeout
    busy_stuck = 1'b1;
    issue(5'd7, 32'd1, 32'd3, 5'd8, 1'b0,
          32'd0, 5'b10000, 65, 1'b1, c0);
    drain();
    busy_stuck = 1'b0;

    // backpressure
    wb_ready = 1'b0;
    issue(5'd4, 32'd1, 32'd2, 5'd31, 1'b1,
          32'd3, 5'b10000, 2, 1'b1, c0);
    n = 0;
    while (!wb_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_wb_valid", wb_valid, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 wb_ready = 1'b1;
    drain();

    // illegal op, NV sticky until cleared
    issue(5'd30, 32'd9, 32'd9, 5'd9, 1'b0,
          32'd0, 5'b10000, 2, 1'b1, c0);
    drain();
    repeat (3) @(negedge clk);
    chk("nv_sticky", fflags, 5'b10000);
    clr_pulse();

    // FCVT range checks
    issue(5'd21, 32'h0000_8000, 32'd0, 5'd10, 1'b0,
          32'h0000_8000, 5'b00100, 2, 1'b1, c0);
    issue(5'd22, 32'h0000_8000, 32'd0, 5'd11, 1'b0,
          32'h0000_8000, 5'b00100, 2, 1'b1, c0);
    issue(5'd21, 32'hffff_8000, 32'd0, 5'd12, 1'b0,
          32'hffff_8000, 5'b00100, 2, 1'b1, c0);
    drain();

    // clear in the capture cycle: old OF drops, new NV stays
    issue(5'd30, 32'd1, 32'd1, 5'd13, 1'b0,
          32'd0, 5'b10000, 2, 1'b1, c0);
    fflags_clr = 1'b1;
    @(posedge clk);
    #1 fflags_clr = 1'b0;
    drain();
    chk("clr_with_capture", fflags, 5'b10000);

    // reset mid-FDIV
    busy_stuck = 1'b1;
    issue(5'd7, 32'd10, 32'd3, 5'd14, 1'b0,
          32'd0, 5'b0, 0, 1'b0, c0);
    repeat (3) @(negedge clk);
    chk("pre_rst_exec", fpu_op, 5'd7);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", issue_ready, 1'b0);
    chk("mid_rst_wb_valid", wb_valid, 1'b0);
    chk("mid_rst_fflags", fflags, 5'b0);
    chk("mid_rst_fpu_op", fpu_op, 5'd8);
    @(negedge clk);
    rst = 1'b0;
    busy_stuck = 1'b0;
    #1;
    chk("rel_ready_low", issue_ready, 1'b0);
    @(negedge clk);
    chk("rel_ready_high", issue_ready, 1'b1);
    repeat (70) @(negedge clk);
    chk("no_wb_after_rst", wb_valid, 1'b0);

    // back-to-back FADDs
    issue(5'd4, 32'd1, 32'd2, 5'd1, 1'b0,
          32'd3, 5'b0, 2, 1'b1, c0);
    issue(5'd4, 32'd10, 32'd20, 5'd2, 1'b1,
          32'd30, 5'b0, 2, 1'b1, c1);
    chk("b2b_gap", c1 - c0, GAP);
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/t07_fpu_issue_ctrl.md
Name: t07_fpu_issue_ctrl

Overview:
- Sequencing stage wrapped around t07_FPU.
- Accepts one decoded FP instruction at a time from the decode/regfile-read stage over a valid/ready handshake, latches its operands and drives them into the FPU.
- Waits out the multi-cycle divide, then presents the captured result to the register writeback stage over a second valid/ready handshake.
- Keeps the sticky fflags (NV/DZ/OF/UF/NX) that feed fcsr.

Parameters:
- DIV_TIMEOUT, 64: max cycles spent waiting for fpu_busy to drop on FDIV before forced completion.
- IDLE_OP, 5'd8: FPUOp driven when no instruction is executing (FSQRT slot: result 0, never busy).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- issue_valid  in  1  instruction offered
- issue_ready  out  1  controller can accept
- issue_op  in  5  FPUOp encoding 0..23
- issue_a, issue_b, issue_c  in  32 each  rs1/rs2/rs3 values
- issue_rd  in  5  destination register index
- issue_int_dest  in  1  1 = result goes to the integer regfile
- fpu_op  out  5  to FPU FPUOp
- fpu_a, fpu_b, fpu_c  out  32 each  to FPU valA/valB/valC
- fpu_result  in  32  FPU result
- fpu_busy  in  1  FPU busy
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_data  out  32  result
- wb_rd  out  5  destination index
- wb_int_dest  out  1  regfile select
- fflags  out  5  sticky flags {NV,DZ,OF,UF,NX}
- fflags_clr  in  1  clear sticky flags (fcsr write)

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high.
- Reset behaviour:
  - While rst is high: state=IDLE; all latches, wb_* and fflags are 0; issue_ready=0.
  - issue_ready rises in the first cycle after rst falls.
  - Reset mid-EXEC or mid-WB discards the instruction; there is no writeback.
- States: IDLE, EXEC, WB.
- IDLE:
  - issue_ready=1.
  - On issue_valid&issue_ready: latch op/a/b/c/rd/int_dest, clear the cycle counter, go to EXEC.
  - fpu_op=IDLE_OP and fpu_a/b/c=0 in every state except EXEC.
- EXEC, outputs:
  - fpu_op and fpu_a/b/c are driven from the latches.
  - The cycle counter increments each cycle.
- EXEC, completion rules:
  - Non-FDIV op 0..23: capture fpu_result at the end of the first EXEC cycle, go to WB. Accept-to-wb_valid latency is 2 cycles.
  - FDIV (op 7) with b==0: do not wait. Result = 32'h7FFF_FFFF if a[31]==0, else 32'h8000_0000. Set DZ. Go to WB.
  - FDIV with b!=0: stay in EXEC while fpu_busy=1. Capture fpu_result in the first cycle with fpu_busy=0. The minimum is 1 EXEC cycle.
  - FDIV timeout: if the counter reaches DIV_TIMEOUT with fpu_busy still 1, result=0, set NV, go to WB.
  - op 24..31: result=0, set NV, go to WB after 1 EXEC cycle.
  - FCVT.S.W/FCVT.S.WU (21/22) whose latched a cannot be represented (a[31:16] not all copies of a[15] for signed; a[31:16]!=0 for unsigned): set OF, result as returned by the FPU.
- WB:
  - wb_valid=1; wb_data, wb_rd and wb_int_dest are registered and held stable until wb_ready.
  - On wb_valid&wb_ready: return to IDLE.
  - issue_ready=0 (see optional feature).
- fflags:
  - Sticky OR of the flags set at capture time.
  - fflags_clr clears them.
  - fflags_clr in the same cycle as a capture: the new flags remain set and older flags clear.
- issue_valid in non-IDLE states is ignored; no queueing.

Optional Feature:
- Macro: T07_FPU_ISSUE_OVERLAP_EN.
- Defined:
  - In WB, issue_ready = wb_ready. A new instruction is accepted in the same cycle the result is consumed, going WB->EXEC directly.
  - Back-to-back single-cycle ops sustain 1 instruction per 2 cycles.
- Undefined:
  - issue_ready only in IDLE, giving a 1-cycle bubble: 1 instruction per 3 cycles.

Test Plan:
- FADD: op=4, a=5, b=7 issued cycle 0 -> wb_valid cycle 2, wb_data=12, wb_rd echoed, fflags=0.
- FDIV with b=0: op=7, a=100, b=0 -> wb_data=32'h7FFF_FFFF within 2 cycles, fflags=5'b01000. Repeat with a=-100 -> 32'h8000_0000.
- FDIV stall: fpu_busy held high 10 cycles then low with fpu_result=25 -> wb_data=25 exactly 1 cycle after busy falls.
- FDIV timeout: fpu_busy stuck at 1, DIV_TIMEOUT=64 -> wb_valid after 64 EXEC cycles, wb_data=0, NV set.
- Backpressure and illegal op: wb_ready low 5 cycles -> wb_* stable, issue_ready=0. Then op=30 -> wb_data=0 and NV sticky until fflags_clr pulse.
- Reset mid-FDIV: rst asserted in EXEC -> wb_valid never rises, fflags=0, issue_ready=1 one cycle after release.
- Overlap (macro defined): two FADDs with wb_ready=1 -> second accepted in the first's WB cycle, wb_valid at cycles 2 and 4.
